// File: rtl/fir_tap_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fir_tap_sequencer
//   Time-multiplexed controller for a shift-coefficient FIR filter. A single
//   shared W-bit adder is stepped across the taps, one tap per cycle. Each tap
//   term is the delayed sample logically shifted right by a programmable amount.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   x          input sample;           in_valid / in_ready handshake
//   dataout    filter result;          out_valid / out_ready handshake
//   cfg_we     shift-table write strobe (honoured only while idle)
//   cfg_addr   tap index to write
//   cfg_shift  right-shift amount for that tap
//   busy       high while accumulating or holding a result
// ---------------------------------------------------------------------------
module fir_tap_sequencer #(
    parameter int W    = 16,
    parameter int TAPS = 5,
    parameter int SW   = 4,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  x,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  dataout,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [SW-1:0] cfg_shift,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [W-1:0]  acc_reg;
    logic [W-1:0]  dataout_reg;
    logic [AW-1:0] idx_reg;
    logic [W-1:0]  d_reg  [TAPS];
    logic [SW-1:0] sh_reg [TAPS];
    logic [W-1:0]  tap_term [TAPS];

    logic          accept;
    logic          cfg_hit;
    logic          last_tap;
    logic [W-1:0]  term_sel;
    logic [W-1:0]  sum;

    assign accept   = in_valid && (state_reg == IDLE);
    // Out-of-range addresses are dropped rather than aliased onto a real tap.
    assign cfg_hit  = cfg_we && (state_reg == IDLE) &&
                      ({1'b0, cfg_addr} < (AW+1)'(TAPS));
    assign last_tap = (idx_reg == AW'(TAPS-1));

    // Shared adder: carry out of bit W-1 is discarded (modulo 2^W).
    assign sum = acc_reg + term_sel;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == OUT);
    assign busy      = (state_reg != IDLE);
    assign dataout   = dataout_reg;

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            // Delay line: moves only on an accepted sample.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    d_reg[gi] <= '0;
                end else if (accept) begin
                    if (gi == 0) begin
                        d_reg[gi] <= x;
                    end else begin
                        d_reg[gi] <= d_reg[(gi > 0) ? gi-1 : 0];
                    end
                end
            end

            // Shift table; default ramp TAPS..1 so older samples weigh more.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sh_reg[gi] <= SW'(TAPS - gi);
                end else if (cfg_hit && (cfg_addr == AW'(gi))) begin
                    sh_reg[gi] <= cfg_shift;
                end
            end

            // Logical shift; amounts >= W naturally produce zero.
            assign tap_term[gi] = d_reg[gi] >> sh_reg[gi];
        end
    endgenerate

    // Tap select; indices beyond the table contribute nothing.
    always_comb begin
        term_sel = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (idx_reg == AW'(k)) begin
                term_sel = tap_term[k];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid)  state_next = ACC;
            ACC:  if (last_tap)  state_next = OUT;
            OUT:  if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg     <= '0;
            idx_reg     <= '0;
            dataout_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        acc_reg <= '0;
                        idx_reg <= '0;
                    end
                end
                ACC: begin
                    acc_reg <= sum;
                    idx_reg <= idx_reg + 1'b1;
                    if (last_tap) begin
                        dataout_reg <= sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
`timescale 1ns/1ps
module tb_fir_tap_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] x = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dataout;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [3:0]  cfg_shift = '0;
    logic        busy;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic prev_ov = 1'b0;

    fir_tap_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataout   (dataout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_shift (cfg_shift),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    endtask

    // Output monitor: latency on the rising edge of out_valid, data on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                if (out_valid && !prev_ov) begin
                    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) check("latency", 32'(cyc - sb[0].cyc), 32'd5);
                end
                if (out_valid && out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    $display("out  dataout=%h expected=%h", dataout, e.data);
                    check("dataout", 32'(dataout), 32'(e.data));
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [3:0] s);
        cfg_we = 1'b1; cfg_addr = a; cfg_shift = s;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] v, input logic [15:0] e);
        bit ok = 1'b0;
        x = v; in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (in_ready) begin
                sb.push_back('{data: e, cyc: cyc + 1});
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        $display("send x=%h expected=%h", v, e);
        check("accept", 32'(ok), 32'd1);
        if (ok) @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_ov();
        bit ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (out_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("out_valid_rise", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [15:0] imp [5];
        imp[0] = 16'h0008; imp[1] = 16'h0018; imp[2] = 16'h0038;
        imp[3] = 16'h0078; imp[4] = 16'h00F8;

        do_reset();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_dataout",   32'(dataout),   32'd0);

        // Impulse response with default shifts.
        for (int i = 0; i < 5; i++) send(16'h0100, imp[i]);
        drain();

        // Wrap-around with all shifts zero.
        do_reset();
        for (int i = 0; i < 5; i++) cfg_write(3'(i), 4'd0);
        for (int i = 1; i <= 5; i++) send(16'hFFFF, 16'(32'h10000 - i));
        drain();

        // Backpressure: result held, no acceptance while waiting.
        do_reset();
        out_ready = 1'b0;
        send(16'h0100, 16'h0008);
        wait_ov();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            x = 16'($urandom);
            #2;
            check("bp_dataout",   32'(dataout),   32'h0008);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        send(16'h0100, 16'h0018);
        drain();

        // Config writes while busy and to an out-of-range address are ignored.
        do_reset();
        send(16'h0100, 16'h0008);
        cfg_write(3'd0, 4'd0);
        drain();
        cfg_write(3'd5, 4'd0);
        cfg_write(3'd7, 4'd0);
        send(16'h0100, 16'h0018);
        drain();

        // Largest shift; write lands in the same cycle as the accept.
        do_reset();
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_shift = 4'd15;
        send(16'h8000, 16'h0001);
        cfg_we = 1'b0;
        drain();

        // Asynchronous reset while holding a result.
        do_reset();
        out_ready = 1'b0;
        send(16'h0100, 16'h0008);
        wait_ov();
        #3 rst = 1'b0;
        sb.delete();
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_dataout",   32'(dataout),   32'd0);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Asynchronous reset mid-accumulation restores shifts and clears history.
        cfg_write(3'd1, 4'd0);
        send(16'h0100, 16'h0000);
        #3 rst = 1'b0;
        sb.delete();
        #1;
        check("arst_acc_busy",     32'(busy),      32'd0);
        check("arst_acc_in_ready", 32'(in_ready),  32'd1);
        check("arst_acc_ov",       32'(out_valid), 32'd0);
        #1 rst = 1'b1;
        @(negedge clk);
        send(16'h0100, 16'h0008);
        drain();
        send(16'h0100, 16'h0018);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
